// File: rtl/dncdaq_pkg.sv
// Shared definitions for the TX FIFO burst arbiter: FSM state encoding and settle timing.
package dncdaq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XFER   = 2'd1,
    ST_SETTLE = 2'd2
  } arb_state_e;

  // Cycles spent after a burst so the last registered write is reflected in dcnt.
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned SETTLE_CW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first asserted request at or after the pointer, wrapping.
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_idx,
  output logic            o_found
);

  int unsigned w_j;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_j = (32'(i_ptr) + k) % NREQ;
      if (!o_found && i_req[IDW'(w_j)]) begin
        o_idx   = IDW'(w_j);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_fifo_burst_arb.sv
// Round-robin burst arbiter sharing the TX FIFO write port; grants only when
// the whole burst fits, then streams the granted requester's words into the FIFO.
module tx_fifo_burst_arb
  import dncdaq_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned DW      = 32,
  parameter  int unsigned FIFO_AW = 10,
  parameter  int unsigned BW      = 4,
  localparam int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*BW-1:0]   i_req_len,
  output logic [NREQ-1:0]      o_req_grant,
  output logic [IDW-1:0]       o_grant_id,
  input  logic [NREQ-1:0]      i_s_valid,
  input  logic [NREQ*DW-1:0]   i_s_data,
  output logic [NREQ-1:0]      o_s_ready,
  output logic                 o_tx_fifo_wr,
  output logic [DW-1:0]        o_tx_fifo_din,
  input  logic [FIFO_AW-1:0]   i_tx_fifo_dcnt,
  input  logic                 i_tx_fifo_clr,
  output logic                 o_busy,
  output logic                 o_burst_done,
  output logic                 o_burst_abort
);

  localparam int unsigned        CW       = FIFO_AW + 1;
  localparam logic [FIFO_AW-1:0] FIFO_CAP = '1;

  arb_state_e           r_state;
  logic [IDW-1:0]       r_ptr;
  logic [IDW-1:0]       r_grant_id;
  logic [BW-1:0]        r_remaining;
  logic [SETTLE_CW-1:0] r_settle_cnt;
  logic [NREQ-1:0]      r_req_grant;
  logic                 r_wr;
  logic [DW-1:0]        r_din;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_abort;

  logic [IDW-1:0]       w_cand;
  logic                 w_found;
  logic [BW-1:0]        w_cand_len;
  logic [FIFO_AW-1:0]   w_free;
  logic                 w_fits;
  logic [NREQ-1:0]      w_cand_onehot;
  logic [NREQ-1:0]      w_gid_onehot;
  logic [DW-1:0]        w_sdata;
  logic                 w_beat;
  logic [IDW-1:0]       w_next_ptr;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_cand),
    .o_found (w_found)
  );

  // Space check: burst of len+1 words against free slots, widened to avoid wrap.
  assign w_cand_len    = i_req_len[32'(w_cand)*BW +: BW];
  assign w_free        = FIFO_CAP - i_tx_fifo_dcnt;
  assign w_fits        = (CW'(w_cand_len) + CW'(1)) <= CW'(w_free);
  assign w_cand_onehot = NREQ'(1) << w_cand;
  assign w_gid_onehot  = NREQ'(1) << r_grant_id;
  assign w_sdata       = i_s_data[32'(r_grant_id)*DW +: DW];
  assign w_next_ptr    = (32'(r_grant_id) == NREQ - 1) ? '0 : r_grant_id + IDW'(1);

  assign o_s_ready = (r_state == ST_XFER && !i_tx_fifo_clr) ? w_gid_onehot : '0;
  assign w_beat    = |(i_s_valid & o_s_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_grant_id   <= '0;
      r_remaining  <= '0;
      r_settle_cnt <= '0;
      r_req_grant  <= '0;
      r_wr         <= 1'b0;
      r_din        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found && w_fits && !i_tx_fifo_clr) begin
            r_state     <= ST_XFER;
            r_grant_id  <= w_cand;
            r_remaining <= w_cand_len;
            r_req_grant <= w_cand_onehot;
            r_busy      <= 1'b1;
          end
        end
        ST_XFER: begin
          if (i_tx_fifo_clr) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
            r_req_grant  <= '0;
            r_ptr        <= w_next_ptr;
            r_abort      <= 1'b1;
          end else if (w_beat) begin
            r_wr  <= 1'b1;
            r_din <= w_sdata;
            if (r_remaining == '0) begin
              r_state      <= ST_SETTLE;
              r_settle_cnt <= '0;
              r_req_grant  <= '0;
              r_ptr        <= w_next_ptr;
              r_done       <= 1'b1;
            end else begin
              r_remaining <= r_remaining - BW'(1);
            end
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == SETTLE_CW'(SETTLE_CYC - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_settle_cnt <= r_settle_cnt + SETTLE_CW'(1);
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_grant <= '0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_grant   = r_req_grant;
  assign o_grant_id    = r_grant_id;
  assign o_tx_fifo_wr  = r_wr;
  assign o_tx_fifo_din = r_din;
  assign o_busy        = r_busy;
  assign o_burst_done  = r_done;
  assign o_burst_abort = r_abort;

endmodule

// File: tb/tb_tx_fifo_burst_arb.sv
// Bench for tx_fifo_burst_arb: directed scenarios plus random traffic against a
// transaction-level model of grants, FIFO writes and burst completion.
module tb_tx_fifo_burst_arb;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned FIFO_AW = 4;
  localparam int unsigned BW      = 4;
  localparam int          CAP     = 15;
  localparam int          SETTLE  = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [15:0]  req_len;
  logic [3:0]   req_grant;
  logic [1:0]   grant_id;
  logic [3:0]   s_valid;
  logic [127:0] s_data;
  logic [3:0]   s_ready;
  logic         wr;
  logic [31:0]  din;
  logic [3:0]   dcnt;
  logic         clr;
  logic         busy;
  logic         done;
  logic         abort_p;

  always #5 clk = ~clk;

  tx_fifo_burst_arb #(.NREQ(NREQ), .DW(DW), .FIFO_AW(FIFO_AW), .BW(BW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .i_req_len      (req_len),
    .o_req_grant    (req_grant),
    .o_grant_id     (grant_id),
    .i_s_valid      (s_valid),
    .i_s_data       (s_data),
    .o_s_ready      (s_ready),
    .o_tx_fifo_wr   (wr),
    .o_tx_fifo_din  (din),
    .i_tx_fifo_dcnt (dcnt),
    .i_tx_fifo_clr  (clr),
    .o_busy         (busy),
    .o_burst_done   (done),
    .o_burst_abort  (abort_p)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus for the next cycle.
  logic        d_rst;
  logic [3:0]  d_valid;
  logic [15:0] d_len;
  logic [3:0]  d_sval;
  logic [3:0]  d_dcnt;
  logic        d_clr;

  // Transaction model: active burst, words left, settle cycles left, rr pointer.
  bit          m_xfer   = 1'b0;
  int          m_gid    = 0;
  int          m_left   = 0;
  int          m_settle = 0;
  int          m_ptr    = 0;
  logic [31:0] cur_data [4];

  logic [3:0]  e_grant = '0;
  logic [1:0]  e_gid   = '0;
  logic        e_busy  = 1'b0;
  logic        e_wr    = 1'b0;
  logic [31:0] e_din   = '0;
  logic        e_done  = 1'b0;
  logic        e_abort = 1'b0;
  logic [3:0]  e_ready;
  logic [45:0] obs_vec;
  logic [45:0] exp_vec;

  // One cycle: apply stimulus, capture observed vs model outputs, advance the model.
  task automatic step();
    int cand;
    @(negedge clk);
    rst = d_rst; req_valid = d_valid; req_len = d_len;
    s_valid = d_sval; dcnt = d_dcnt; clr = d_clr;
    for (int r = 0; r < 4; r++) s_data[r*32 +: 32] = cur_data[r];
    #1;
    e_ready = (m_xfer && !d_clr) ? 4'(1 << m_gid) : 4'd0;
    obs_vec = {req_grant, grant_id, busy, wr, (wr ? din : 32'd0), done, abort_p, s_ready};
    exp_vec = {e_grant, e_gid, e_busy, e_wr, (e_wr ? e_din : 32'd0), e_done, e_abort, e_ready};
    e_wr = 1'b0; e_done = 1'b0; e_abort = 1'b0;
    if (d_rst) begin
      m_xfer = 1'b0; m_settle = 0; m_ptr = 0; m_gid = 0;
    end else if (m_xfer) begin
      if (d_clr) begin
        m_xfer = 1'b0; m_settle = SETTLE; m_ptr = (m_gid + 1) % 4; e_abort = 1'b1;
      end else if (d_sval[m_gid]) begin
        e_wr = 1'b1; e_din = cur_data[m_gid]; cur_data[m_gid] = $urandom;
        if (m_left == 0) begin
          m_xfer = 1'b0; m_settle = SETTLE; m_ptr = (m_gid + 1) % 4; e_done = 1'b1;
        end else begin
          m_left--;
        end
      end
    end else if (m_settle > 0) begin
      m_settle--;
    end else begin
      cand = -1;
      for (int k = 0; k < 4; k++)
        if (cand < 0 && d_valid[(m_ptr + k) % 4]) cand = (m_ptr + k) % 4;
      if (cand >= 0 && !d_clr && int'(d_len[cand*4 +: 4]) + 1 <= CAP - int'(d_dcnt)) begin
        m_xfer = 1'b1; m_gid = cand; m_left = int'(d_len[cand*4 +: 4]);
      end
    end
    e_busy  = m_xfer || (m_settle > 0);
    e_grant = m_xfer ? 4'(1 << m_gid) : 4'd0;
    e_gid   = 2'(m_gid);
  endtask

  task automatic test_reset();
    d_rst = 1'b1; d_valid = '0; d_len = '0; d_sval = '0; d_dcnt = '0; d_clr = 1'b0;
    step();
    step();
    if (obs_vec !== 46'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", obs_vec); end
    checks++;
    d_rst = 1'b0;
    step();
    if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_idle got %h want %h", obs_vec, exp_vec); end
    checks++;
    if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    checks++;
  endtask

  task automatic test_single();
    int nw = 0, nd = 0;
    d_valid = 4'b0010; d_len = 16'h0030; d_sval = 4'hF; d_dcnt = '0;
    step();
    d_valid = '0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL single c%0d got %h want %h", k, obs_vec, exp_vec); end
      checks++;
      if (k == 1) begin
        if (req_grant !== 4'b0010) begin errors++; $display("FAIL single_grant got %b want 0010", req_grant); end
        checks++;
      end
      if (k == 6 || k == 7) begin
        if (busy !== (k == 6)) begin errors++; $display("FAIL single_busy c%0d got %b want %b", k, busy, k == 6); end
        checks++;
      end
      nw += int'(wr); nd += int'(done);
    end
    if (nw != 4 || nd != 1) begin errors++; $display("FAIL single_counts got wr=%0d done=%0d want 4/1", nw, nd); end
    checks++;
  endtask

  task automatic test_round_robin();
    int start = m_ptr, ng = 0;
    logic [3:0] prev = '0;
    d_valid = 4'hF; d_len = '0; d_sval = 4'hF;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      step();
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL rr c%0d got %h want %h", c, obs_vec, exp_vec); end
      checks++;
      if (req_grant !== 4'd0 && prev === 4'd0) begin
        if (grant_id !== 2'((start + ng) % 4)) begin
          errors++; $display("FAIL rr_order n%0d got %0d want %0d", ng, grant_id, (start + ng) % 4);
        end
        checks++;
        ng++;
      end
      prev = req_grant;
    end
    if (ng != 5) begin errors++; $display("FAIL rr_timeout got %0d grants want 5", ng); end
    checks++;
    d_valid = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL rr_drain got %h want %h", obs_vec, exp_vec); end
      checks++;
    end
  endtask

  task automatic test_space_gating();
    d_valid = 4'b0001; d_len = 16'h0007; d_dcnt = 4'd10; d_sval = 4'hF;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) d_valid = 4'b0011;
      step();
      if (req_grant !== 4'd0 || obs_vec !== exp_vec) begin
        errors++; $display("FAIL gate_hold c%0d got %h want %h", c, obs_vec, exp_vec);
      end
      checks++;
    end
    d_dcnt = 4'd7;
    step();
    d_valid = '0; d_dcnt = '0;
    step();
    if (req_grant !== 4'b0001) begin errors++; $display("FAIL gate_grant got %b want 0001", req_grant); end
    checks++;
    for (int c = 0; c < 12; c++) begin
      step();
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL gate_burst c%0d got %h want %h", c, obs_vec, exp_vec); end
      checks++;
    end
  endtask

  task automatic test_backpressure();
    int nw = 0, nd = 0;
    d_valid = 4'b0010; d_len = 16'h0030; d_sval = '0;
    step();
    d_valid = '0;
    for (int c = 0; c < 12; c++) begin
      d_sval = (c % 2 == 0) ? 4'b0010 : 4'b0000;
      step();
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL bp c%0d got %h want %h", c, obs_vec, exp_vec); end
      checks++;
      if (wr !== (c % 2 == 1 && c <= 7)) begin errors++; $display("FAIL bp_wr c%0d got %b", c, wr); end
      checks++;
      nw += int'(wr);
      if (done === 1'b1) begin
        nd++;
        if (nw != 4) begin errors++; $display("FAIL bp_done_at got wr=%0d want 4", nw); end
        checks++;
      end
    end
    if (nd != 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", nd); end
    checks++;
  endtask

  task automatic test_abort();
    int nw = 0, na = 0;
    d_valid = 4'b0100; d_len = 16'h0700; d_sval = 4'hF;
    step();
    d_valid = '0;
    for (int c = 0; c < 2; c++) begin
      step(); nw += int'(wr);
    end
    d_clr = 1'b1;
    step(); nw += int'(wr);
    if (s_ready !== 4'd0) begin errors++; $display("FAIL abort_ready got %b want 0000", s_ready); end
    checks++;
    d_clr = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL abort c%0d got %h want %h", c, obs_vec, exp_vec); end
      checks++;
      nw += int'(wr); na += int'(abort_p);
      if (c == 2 || c == 3) begin
        if (busy !== (c == 2)) begin errors++; $display("FAIL abort_busy c%0d got %b", c, busy); end
        checks++;
      end
    end
    if (nw != 2 || na != 1) begin errors++; $display("FAIL abort_counts got wr=%0d abort=%0d want 2/1", nw, na); end
    checks++;
    d_valid = 4'b1100; d_len = '0;
    step();
    d_valid = '0;
    step();
    if (req_grant !== 4'b1000 || grant_id !== 2'd3) begin
      errors++; $display("FAIL abort_rr got %b/%0d want 1000/3", req_grant, grant_id);
    end
    checks++;
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      d_valid = 4'($urandom); d_len = 16'($urandom); d_dcnt = 4'($urandom);
      d_sval = 4'($urandom) | 4'($urandom);
      d_clr = ($urandom_range(0, 39) == 0);
      step();
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL random c%0d got %h want %h", c, obs_vec, exp_vec); end
      checks++;
    end
    d_valid = '0; d_clr = 1'b0; d_sval = 4'hF; d_dcnt = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL random_drain got %h want %h", obs_vec, exp_vec); end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    d_valid = 4'hF; d_len = 16'h7777; d_sval = 4'hF;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (req_grant !== 4'd0) got = 1'b1;
    end
    if (!got) begin errors++; $display("FAIL rstmid_timeout got no grant"); end
    checks++;
    step();
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    step();
    if (obs_vec !== 46'd0) begin errors++; $display("FAIL rstmid_outputs got %h want 0", obs_vec); end
    checks++;
    d_valid = '0;
    step();
    if (req_grant !== 4'b0001 || grant_id !== 2'd0) begin
      errors++; $display("FAIL rstmid_grant got %b/%0d want 0001/0", req_grant, grant_id);
    end
    checks++;
    for (int c = 0; c < 12; c++) begin
      step();
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL rstmid_burst got %h want %h", obs_vec, exp_vec); end
      checks++;
    end
  endtask

  initial begin
    for (int r = 0; r < 4; r++) cur_data[r] = $urandom;
    rst = 1'b1; req_valid = '0; req_len = '0; s_valid = '0; s_data = '0; dcnt = '0; clr = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_space_gating();
    test_backpressure();
    test_abort();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
